// File: rtl/qa_drv_hc_fifo_from_host_unpack.sv
// Unpacks framed host-to-FPGA cache lines (header chunk + payload chunks) into a
// valid/ready chunk stream, with consumed/dropped line statistics.
module qa_drv_hc_fifo_from_host_unpack #(
  parameter int unsigned LINE_BITS  = 512,
  parameter int unsigned CHUNK_BITS = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LINE_BITS-1:0]  rx_data,
  input  logic                  rx_rdy,
  output logic                  rx_enable,
  output logic [CHUNK_BITS-1:0] chunk_data,
  output logic                  chunk_valid,
  output logic                  chunk_last,
  input  logic                  chunk_ready,
  output logic [31:0]           lines_consumed,
  output logic [31:0]           lines_dropped,
  output logic                  count_err
);

  localparam int unsigned N_CHUNKS = LINE_BITS / CHUNK_BITS;
  localparam int unsigned IDX_W    = $clog2(N_CHUNKS);
  localparam logic [7:0]  MAX_CNT  = 8'(N_CHUNKS - 1);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e                 state_q;
  logic [LINE_BITS-1:0]   line_q;
  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       cnt_q;
  logic [31:0]            lines_consumed_q;
  logic [31:0]            lines_dropped_q;
  logic                   count_err_q;

  logic [7:0]             hdr_cnt;
  logic                   hdr_over;
  logic [IDX_W-1:0]       cnt_clamped;
  logic                   is_last;
  logic [CHUNK_BITS-1:0]  chunks [N_CHUNKS];

  // Header decode and clamp of the incoming line
  assign hdr_cnt     = rx_data[7:0];
  assign hdr_over    = hdr_cnt > MAX_CNT;
  assign cnt_clamped = hdr_over ? IDX_W'(MAX_CNT) : IDX_W'(hdr_cnt);
  assign is_last     = idx_q == cnt_q;

  // Dequeue when empty, or when the final chunk of the held line is being taken
  assign rx_enable = !reset && rx_rdy &&
                     (state_q == IDLE || (state_q == EMIT && chunk_ready && is_last));

  for (genvar g = 0; g < N_CHUNKS; g++) begin : g_chunk
    assign chunks[g] = line_q[g*CHUNK_BITS +: CHUNK_BITS];
  end

  assign chunk_valid    = state_q == EMIT;
  assign chunk_last     = (state_q == EMIT) && is_last;
  assign chunk_data     = chunks[idx_q];
  assign lines_consumed = lines_consumed_q;
  assign lines_dropped  = lines_dropped_q;
  assign count_err      = count_err_q;

  // Line storage needs no reset: it is only observed in EMIT
  always_ff @(posedge clk) begin
    if (rx_enable) line_q <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      cnt_q            <= '0;
      lines_consumed_q <= '0;
      lines_dropped_q  <= '0;
      count_err_q      <= 1'b0;
    end else if (rx_enable) begin
      lines_consumed_q <= lines_consumed_q + 32'd1;
      if (hdr_over) count_err_q <= 1'b1;
      if (hdr_cnt == 8'd0) begin
        lines_dropped_q <= lines_dropped_q + 32'd1;
        state_q         <= IDLE;
      end else begin
        state_q <= EMIT;
        idx_q   <= IDX_W'(1);
        cnt_q   <= cnt_clamped;
      end
    end else if (state_q == EMIT && chunk_ready) begin
      if (is_last) state_q <= IDLE;
      else         idx_q   <= idx_q + IDX_W'(1);
    end
  end

`ifndef SYNTHESIS
  // The FIFO reader presents its head entry until it is dequeued
  rx_rdy_held_a: assert property (@(posedge clk) disable iff (reset)
    (rx_rdy && !rx_enable) |=> rx_rdy);
`endif

endmodule

// File: tb/tb_qa_drv_hc_fifo_from_host_unpack.sv
// Scoreboard bench for qa_drv_hc_fifo_from_host_unpack: lines are modelled at
// dequeue, chunks popped and compared at each output handshake.
module tb_qa_drv_hc_fifo_from_host_unpack;
  localparam int unsigned LB = 512;
  localparam int unsigned CB = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [LB-1:0] rx_data;
  logic          rx_rdy;
  logic          rx_enable;
  logic [CB-1:0] chunk_data;
  logic          chunk_valid;
  logic          chunk_last;
  logic          chunk_ready;
  logic [31:0]   lines_consumed;
  logic [31:0]   lines_dropped;
  logic          count_err;

  qa_drv_hc_fifo_from_host_unpack #(.LINE_BITS(LB), .CHUNK_BITS(CB)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_enable(rx_enable),
    .chunk_data(chunk_data), .chunk_valid(chunk_valid), .chunk_last(chunk_last),
    .chunk_ready(chunk_ready), .lines_consumed(lines_consumed),
    .lines_dropped(lines_dropped), .count_err(count_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CB-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  int            n_pops = 0;
  bit            prev_stall = 1'b0;
  logic [CB-1:0] prev_data;
  logic          prev_last;

  // Monitor: stall stability, output scoreboard, and reference model at dequeue
  always @(negedge clk) begin
    exp_t        e;
    int unsigned c;
    #2;
    if (reset === 1'b1) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (chunk_valid !== 1'b1 || chunk_data !== prev_data || chunk_last !== prev_last) begin
          failures++;
          $display("FAIL stall_hold got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                   chunk_valid, chunk_data, chunk_last, prev_data, prev_last);
        end
      end
      if (chunk_valid === 1'b1 && chunk_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_chunk got d=%h l=%b exp none", chunk_data, chunk_last);
        end else begin
          e = sb.pop_front();
          n_pops++;
          if (chunk_data !== e.data || chunk_last !== e.last) begin
            failures++;
            $display("FAIL chunk_seq got d=%h l=%b exp d=%h l=%b",
                     chunk_data, chunk_last, e.data, e.last);
          end
        end
      end
      prev_stall = (chunk_valid === 1'b1) && (chunk_ready !== 1'b1);
      prev_data  = chunk_data;
      prev_last  = chunk_last;
      if (rx_enable === 1'b1) begin
        checks++;
        if (rx_rdy !== 1'b1) begin
          failures++;
          $display("FAIL enable_without_rdy got rx_rdy=%b exp 1", rx_rdy);
        end
        c = 32'(rx_data[7:0]);
        if (c > 7) c = 7;
        for (int k = 1; k <= int'(c); k++) begin
          e.data = rx_data[k*CB +: CB];
          e.last = (k == int'(c));
          sb.push_back(e);
        end
      end
    end
  end

  function automatic logic [LB-1:0] make_line(input logic [7:0] cnt, input logic [15:0] tag);
    logic [LB-1:0] l;
    l = '0;
    for (int k = 1; k < 8; k++) l[k*CB +: CB] = {16'h1111, tag, 32'(k)};
    l[7:0] = cnt;
    return l;
  endfunction

  function automatic logic [LB-1:0] rand_line(input logic [7:0] cnt);
    logic [LB-1:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
    l[7:0] = cnt;
    return l;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rx_rdy = 1'b0; chunk_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_line(input logic [LB-1:0] line, input bit rand_ready);
    int guard = 0;
    do begin
      @(negedge clk);
      chunk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_data = line; rx_rdy = 1'b1;
      #3;
      guard++;
    end while (rx_enable !== 1'b1 && guard < 200);
    if (guard >= 200) begin
      checks++; failures++;
      $display("FAIL send_timeout got rx_enable=%b exp 1", rx_enable);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    do begin
      @(negedge clk);
      rx_rdy = 1'b0; chunk_ready = 1'b1;
      #3;
      guard++;
    end while (!(chunk_valid === 1'b0 && sb.size() == 0) && guard < 200);
    checks++;
    if (guard >= 200) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d valid=%b exp pending=0 valid=0",
               sb.size(), chunk_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; rx_rdy = 1'b1; chunk_ready = 1'b1; rx_data = make_line(8'd3, 16'h0);
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++;
      if (rx_enable !== 1'b0) begin
        failures++; $display("FAIL reset_no_enable got %b exp 0", rx_enable);
      end
      @(negedge clk);
    end
    #3;
    checks++;
    if (chunk_valid !== 1'b0 || chunk_last !== 1'b0 || lines_consumed !== 32'd0 ||
        lines_dropped !== 32'd0 || count_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got v=%b l=%b c=%0d d=%0d e=%b exp all 0",
               chunk_valid, chunk_last, lines_consumed, lines_dropped, count_err);
    end
    @(negedge clk);
    reset = 1'b0; rx_rdy = 1'b0;
  endtask

  task automatic test_single();
    int extra_en = 0;
    do_reset();
    @(negedge clk);
    rx_data = make_line(8'd7, 16'h0); rx_rdy = 1'b1; chunk_ready = 1'b1;
    #3;
    checks++;
    if (rx_enable !== 1'b1 || chunk_valid !== 1'b0) begin
      failures++; $display("FAIL single_dequeue got en=%b v=%b exp en=1 v=0", rx_enable, chunk_valid);
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      rx_rdy = 1'b0;
      #3;
      checks++;
      if (chunk_valid !== 1'b1 || chunk_last !== (k == 7) ||
          chunk_data !== (64'h1111_0000_0000_0000 | 64'(k))) begin
        failures++;
        $display("FAIL single_chunk%0d got v=%b l=%b d=%h exp v=1 l=%b d=%h", k, chunk_valid,
                 chunk_last, chunk_data, (k == 7), 64'h1111_0000_0000_0000 | 64'(k));
      end
      if (rx_enable === 1'b1) extra_en++;
    end
    @(negedge clk);
    #3;
    checks++;
    if (chunk_valid !== 1'b0 || extra_en != 0 || lines_consumed !== 32'd1) begin
      failures++;
      $display("FAIL single_end got v=%b extra_en=%0d consumed=%0d exp 0 0 1",
               chunk_valid, extra_en, lines_consumed);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    rx_data = make_line(8'd3, 16'h1); rx_rdy = 1'b1; chunk_ready = 1'b1;
    #3;
    checks++;
    if (rx_enable !== 1'b1) begin
      failures++; $display("FAIL b2b_first_en got %b exp 1", rx_enable);
    end
    @(negedge clk);
    rx_data = make_line(8'd2, 16'h2);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 4) rx_rdy = 1'b0;
      #3;
      checks++;
      if (chunk_valid !== 1'b1 || chunk_last !== (cyc == 3 || cyc == 5) ||
          rx_enable !== (cyc == 3)) begin
        failures++;
        $display("FAIL b2b_cycle%0d got v=%b l=%b en=%b exp v=1 l=%b en=%b", cyc, chunk_valid,
                 chunk_last, rx_enable, (cyc == 3 || cyc == 5), (cyc == 3));
      end
    end
    wait_idle();
    checks++;
    if (lines_consumed !== 32'd2) begin
      failures++; $display("FAIL b2b_consumed got %0d exp 2", lines_consumed);
    end
  endtask

  task automatic test_drop();
    logic [LB-1:0] l1;
    l1 = make_line(8'd1, 16'h4);
    do_reset();
    @(negedge clk);
    rx_data = make_line(8'd0, 16'h3); rx_rdy = 1'b1; chunk_ready = 1'b1;
    #3;
    @(negedge clk);
    rx_data = l1;
    #3;
    checks++;
    if (chunk_valid !== 1'b0 || rx_enable !== 1'b1) begin
      failures++; $display("FAIL drop_gap got v=%b en=%b exp v=0 en=1", chunk_valid, rx_enable);
    end
    @(negedge clk);
    rx_rdy = 1'b0;
    #3;
    checks++;
    if (chunk_valid !== 1'b1 || chunk_last !== 1'b1 || chunk_data !== l1[127:64]) begin
      failures++;
      $display("FAIL drop_next got v=%b l=%b d=%h exp v=1 l=1 d=%h",
               chunk_valid, chunk_last, chunk_data, l1[127:64]);
    end
    wait_idle();
    checks++;
    if (lines_dropped !== 32'd1 || lines_consumed !== 32'd2) begin
      failures++;
      $display("FAIL drop_counts got d=%0d c=%0d exp d=1 c=2", lines_dropped, lines_consumed);
    end
  endtask

  task automatic test_count_err();
    int p;
    do_reset();
    p = n_pops;
    send_line(make_line(8'hFF, 16'h5), 1'b0);
    wait_idle();
    checks++;
    if (n_pops - p != 7 || count_err !== 1'b1) begin
      failures++;
      $display("FAIL err_clamp got chunks=%0d err=%b exp chunks=7 err=1", n_pops - p, count_err);
    end
    send_line(make_line(8'd2, 16'h6), 1'b0);
    wait_idle();
    checks++;
    if (count_err !== 1'b1) begin
      failures++; $display("FAIL err_sticky got %b exp 1", count_err);
    end
    do_reset();
    #3;
    checks++;
    if (count_err !== 1'b0) begin
      failures++; $display("FAIL err_reset got %b exp 0", count_err);
    end
  endtask

  task automatic test_random();
    int zeros = 0;
    logic [7:0] c;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      c = 8'($urandom_range(0, 7));
      if (c == 8'd0) zeros++;
      send_line(rand_line(c), 1'b1);
    end
    wait_idle();
    checks++;
    if (lines_consumed !== 32'd100 || lines_dropped !== 32'(zeros)) begin
      failures++;
      $display("FAIL random_counts got c=%0d d=%0d exp c=100 d=%0d",
               lines_consumed, lines_dropped, zeros);
    end
  endtask

  task automatic test_reset_mid();
    logic [LB-1:0] l, l2;
    l  = make_line(8'd6, 16'h7);
    l2 = make_line(8'd2, 16'h8);
    do_reset();
    @(negedge clk);
    rx_data = l; rx_rdy = 1'b1; chunk_ready = 1'b1;
    #3;
    @(negedge clk);
    rx_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #3;
    checks++;
    if (chunk_valid !== 1'b1 || chunk_data !== l[3*CB +: CB]) begin
      failures++;
      $display("FAIL mid_third got v=%b d=%h exp v=1 d=%h", chunk_valid, chunk_data, l[3*CB +: CB]);
    end
    @(negedge clk);
    reset = 1'b0;
    #3;
    checks++;
    if (chunk_valid !== 1'b0 || lines_consumed !== 32'd0 || lines_dropped !== 32'd0) begin
      failures++;
      $display("FAIL mid_after got v=%b c=%0d d=%0d exp 0 0 0",
               chunk_valid, lines_consumed, lines_dropped);
    end
    @(negedge clk);
    rx_data = l2; rx_rdy = 1'b1;
    #3;
    @(negedge clk);
    rx_rdy = 1'b0;
    #3;
    checks++;
    if (chunk_valid !== 1'b1 || chunk_data !== l2[127:64]) begin
      failures++;
      $display("FAIL mid_restart got v=%b d=%h exp v=1 d=%h", chunk_valid, chunk_data, l2[127:64]);
    end
    wait_idle();
    checks++;
    if (lines_consumed !== 32'd1) begin
      failures++; $display("FAIL mid_consumed got %0d exp 1", lines_consumed);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx_rdy = 1'b0; rx_data = '0; chunk_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_count_err();
    test_random();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL final_pending got %0d exp 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
